// File: rtl/rob_param.sv
// Parametrised reorder buffer: in-order dispatch, out-of-order writeback from the CDB
// and branch unit, in-order commit with store ack handshake and mispredict flush.
module rob_param #(
  parameter int DEPTH   = 8,
  parameter int ENTRY_W = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int REG_W   = 5,
  parameter int PC_W    = 32,
  parameter int BADDR_W = 8,
  parameter int HIST_W  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               disp_valid,
  output logic               disp_ready,
  output logic [ENTRY_W-1:0] disp_tag,
  input  logic [1:0]         disp_op,
  input  logic [REG_W-1:0]   disp_reg,
  input  logic               disp_pred,
  input  logic [PC_W-1:0]    disp_alt_pc,
  input  logic [BADDR_W-1:0] disp_baddr,
  input  logic [ENTRY_W-1:0] chk1_tag,
  input  logic [ENTRY_W-1:0] chk2_tag,
  output logic [DATA_W-1:0]  chk1_value,
  output logic [DATA_W-1:0]  chk2_value,
  output logic               chk1_ready,
  output logic               chk2_ready,
  input  logic               cdb_valid,
  input  logic [ENTRY_W-1:0] cdb_tag,
  input  logic [DATA_W-1:0]  cdb_value,
  input  logic [ADDR_W-1:0]  cdb_addr,
  input  logic               bra_valid,
  input  logic [ENTRY_W-1:0] bra_tag,
  input  logic               bra_taken,
  output logic               reg_we,
  output logic [REG_W-1:0]   reg_name,
  output logic [DATA_W-1:0]  reg_data,
  output logic [ENTRY_W-1:0] reg_tag,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_data,
  input  logic               mem_ack,
  output logic               pc_modify,
  output logic [PC_W-1:0]    npc,
  output logic               brp_update,
  output logic [BADDR_W-1:0] brp_addr,
  output logic               brp_taken,
  output logic [HIST_W-1:0]  brp_pattern,
  output logic [ENTRY_W:0]   count
);

  typedef enum logic [1:0] {OP_NOP = 2'd0, OP_BRANCH = 2'd1, OP_STORE = 2'd2, OP_NORMAL = 2'd3} op_e;

  localparam logic [ENTRY_W:0] FULL = (ENTRY_W+1)'(DEPTH);

  op_e                ent_op_q    [DEPTH];
  logic [REG_W-1:0]   ent_reg_q   [DEPTH];
  logic               ent_pred_q  [DEPTH];
  logic               ent_taken_q [DEPTH];
  logic [PC_W-1:0]    ent_alt_q   [DEPTH];
  logic [BADDR_W-1:0] ent_baddr_q [DEPTH];
  logic [DATA_W-1:0]  ent_value_q [DEPTH];
  logic [ADDR_W-1:0]  ent_addr_q  [DEPTH];

  logic [DEPTH-1:0]   valid_q, valid_d, done_q, done_d;
  logic [ENTRY_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [ENTRY_W:0]   count_q, count_d;
  logic [HIST_W-1:0]  hist_q, hist_d;
  logic               flush_q, flush_d;

  logic               reg_we_q, reg_we_d, mem_we_q, mem_we_d;
  logic               pc_modify_q, pc_modify_d, brp_update_q, brp_update_d, brp_taken_q, brp_taken_d;
  logic [REG_W-1:0]   reg_name_q, reg_name_d;
  logic [DATA_W-1:0]  reg_data_q, reg_data_d, mem_data_q, mem_data_d;
  logic [ENTRY_W-1:0] reg_tag_q, reg_tag_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [PC_W-1:0]    npc_q, npc_d;
  logic [BADDR_W-1:0] brp_addr_q, brp_addr_d;
  logic [HIST_W-1:0]  brp_pattern_q, brp_pattern_d;

  logic cdb_hit, bra_hit, disp_fire, disp_take, retire, flush_now;

  assign disp_ready = (count_q != FULL) && !flush_q;
  assign disp_tag   = tail_q;
  assign count      = count_q;
  assign cdb_hit    = cdb_valid && valid_q[cdb_tag] && !done_q[cdb_tag];
  assign bra_hit    = bra_valid && valid_q[bra_tag] && !done_q[bra_tag];
  assign disp_fire  = disp_valid && disp_ready;

  // A completed entry wins; otherwise a same-cycle CDB result is forwarded.
  function automatic logic [DATA_W:0] lookup(input logic [ENTRY_W-1:0] tag);
    if (valid_q[tag] && done_q[tag]) return {1'b1, ent_value_q[tag]};
    if (cdb_valid && cdb_tag == tag && valid_q[tag]) return {1'b1, cdb_value};
    return '0;
  endfunction

  assign {chk1_ready, chk1_value} = lookup(chk1_tag);
  assign {chk2_ready, chk2_value} = lookup(chk2_tag);

  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    valid_d = valid_q;     done_d = done_q;
    head_d  = head_q;      tail_d = tail_q;
    hist_d  = hist_q;      flush_d = 1'b0;
    retire  = 1'b0;        flush_now = 1'b0;
    reg_we_d = 1'b0;       reg_name_d = reg_name_q;   reg_data_d = reg_data_q; reg_tag_d = reg_tag_q;
    mem_we_d = mem_we_q;   mem_addr_d = mem_addr_q;   mem_data_d = mem_data_q;
    pc_modify_d = 1'b0;    npc_d = npc_q;
    brp_update_d = 1'b0;   brp_addr_d = brp_addr_q;   brp_taken_d = brp_taken_q;
    brp_pattern_d = brp_pattern_q;

    if (cdb_hit) done_d[cdb_tag] = 1'b1;
    if (bra_hit) done_d[bra_tag] = 1'b1;

    // A store in flight owns the commit port until it is acknowledged.
    if (mem_we_q) begin
      if (mem_ack) begin
        retire   = 1'b1;
        mem_we_d = 1'b0;
      end
    end else if (count_q != '0 && valid_q[head_q] && done_q[head_q]) begin
      unique case (ent_op_q[head_q])
        OP_NOP:    retire = 1'b1;
        OP_NORMAL: begin
          retire     = 1'b1;
          reg_we_d   = 1'b1;
          reg_name_d = ent_reg_q[head_q];
          reg_data_d = ent_value_q[head_q];
          reg_tag_d  = head_q;
        end
        OP_STORE: begin
          mem_we_d   = 1'b1;
          mem_addr_d = ent_addr_q[head_q];
          mem_data_d = ent_value_q[head_q];
        end
        OP_BRANCH: begin
          retire        = 1'b1;
          brp_update_d  = 1'b1;
          brp_addr_d    = ent_baddr_q[head_q];
          brp_taken_d   = ent_taken_q[head_q];
          brp_pattern_d = hist_q;
          hist_d        = {hist_q[HIST_W-2:0], ent_taken_q[head_q]};
          if (ent_taken_q[head_q] != ent_pred_q[head_q]) begin
            pc_modify_d = 1'b1;
            npc_d       = ent_alt_q[head_q];
            flush_now   = 1'b1;
          end
        end
      endcase
    end

    disp_take = disp_fire && !flush_now;
    if (retire) begin
      valid_d[head_q] = 1'b0;
      done_d[head_q]  = 1'b0;
      head_d          = head_q + 1'b1;
    end
    if (disp_take) begin
      valid_d[tail_q] = 1'b1;
      done_d[tail_q]  = 1'b0;
      tail_d          = tail_q + 1'b1;
    end
    count_d = count_q + {{ENTRY_W{1'b0}}, disp_take} - {{ENTRY_W{1'b0}}, retire};

    if (flush_now) begin
      valid_d = '0;
      done_d  = '0;
      head_d  = head_q + 1'b1;
      tail_d  = head_q + 1'b1;
      count_d = '0;
      flush_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;  done_q <= '0;  head_q <= '0;  tail_q <= '0;
      count_q <= '0;  hist_q <= '0;  flush_q <= 1'b0;
      reg_we_q <= 1'b0;  reg_name_q <= '0;  reg_data_q <= '0;  reg_tag_q <= '0;
      mem_we_q <= 1'b0;  mem_addr_q <= '0;  mem_data_q <= '0;
      pc_modify_q <= 1'b0;  npc_q <= '0;
      brp_update_q <= 1'b0;  brp_addr_q <= '0;  brp_taken_q <= 1'b0;  brp_pattern_q <= '0;
    end else begin
      valid_q <= valid_d;  done_q <= done_d;  head_q <= head_d;  tail_q <= tail_d;
      count_q <= count_d;  hist_q <= hist_d;  flush_q <= flush_d;
      reg_we_q <= reg_we_d;  reg_name_q <= reg_name_d;  reg_data_q <= reg_data_d;  reg_tag_q <= reg_tag_d;
      mem_we_q <= mem_we_d;  mem_addr_q <= mem_addr_d;  mem_data_q <= mem_data_d;
      pc_modify_q <= pc_modify_d;  npc_q <= npc_d;
      brp_update_q <= brp_update_d;  brp_addr_q <= brp_addr_d;  brp_taken_q <= brp_taken_d;
      brp_pattern_q <= brp_pattern_d;
    end
  end

  // NOTE: entry payload is left unreset; the valid/done bits alone qualify it.
  always_ff @(posedge clk) begin
    if (disp_fire) begin
      ent_op_q[tail_q]    <= op_e'(disp_op);
      ent_reg_q[tail_q]   <= disp_reg;
      ent_pred_q[tail_q]  <= disp_pred;
      ent_alt_q[tail_q]   <= disp_alt_pc;
      ent_baddr_q[tail_q] <= disp_baddr;
    end
    if (cdb_hit) begin
      ent_value_q[cdb_tag] <= cdb_value;
      ent_addr_q[cdb_tag]  <= cdb_addr;
    end
    if (bra_hit) ent_taken_q[bra_tag] <= bra_taken;
  end

  assign reg_we      = reg_we_q;
  assign reg_name    = reg_name_q;
  assign reg_data    = reg_data_q;
  assign reg_tag     = reg_tag_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data    = mem_data_q;
  assign pc_modify   = pc_modify_q;
  assign npc         = npc_q;
  assign brp_update  = brp_update_q;
  assign brp_addr    = brp_addr_q;
  assign brp_taken   = brp_taken_q;
  assign brp_pattern = brp_pattern_q;

endmodule

// File: tb/tb_rob_param.sv
// Directed self-checking bench for rob_param at default parameters (DEPTH=8).
module tb_rob_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        disp_valid, disp_ready, disp_pred;
  logic [2:0]  disp_tag;
  logic [1:0]  disp_op;
  logic [4:0]  disp_reg;
  logic [31:0] disp_alt_pc;
  logic [7:0]  disp_baddr;
  logic [2:0]  chk1_tag, chk2_tag;
  logic [31:0] chk1_value, chk2_value;
  logic        chk1_ready, chk2_ready;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [31:0] cdb_value, cdb_addr;
  logic        bra_valid, bra_taken;
  logic [2:0]  bra_tag;
  logic        reg_we;
  logic [4:0]  reg_name;
  logic [31:0] reg_data;
  logic [2:0]  reg_tag;
  logic        mem_we, mem_ack;
  logic [31:0] mem_addr, mem_data;
  logic        pc_modify, brp_update, brp_taken;
  logic [31:0] npc;
  logic [7:0]  brp_addr;
  logic [1:0]  brp_pattern;
  logic [3:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  rob_param dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_tag(disp_tag),
    .disp_op(disp_op), .disp_reg(disp_reg), .disp_pred(disp_pred),
    .disp_alt_pc(disp_alt_pc), .disp_baddr(disp_baddr),
    .chk1_tag(chk1_tag), .chk2_tag(chk2_tag),
    .chk1_value(chk1_value), .chk2_value(chk2_value),
    .chk1_ready(chk1_ready), .chk2_ready(chk2_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .cdb_addr(cdb_addr),
    .bra_valid(bra_valid), .bra_tag(bra_tag), .bra_taken(bra_taken),
    .reg_we(reg_we), .reg_name(reg_name), .reg_data(reg_data), .reg_tag(reg_tag),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack),
    .pc_modify(pc_modify), .npc(npc),
    .brp_update(brp_update), .brp_addr(brp_addr), .brp_taken(brp_taken),
    .brp_pattern(brp_pattern), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; sampling happens 1 time unit after it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input logic [1:0] op, input logic [4:0] r, input logic pred,
                          input logic [31:0] alt, input logic [7:0] ba);
    disp_valid = 1'b1; disp_op = op; disp_reg = r; disp_pred = pred;
    disp_alt_pc = alt; disp_baddr = ba;
    cycle();
    disp_valid = 1'b0;
  endtask

  task automatic cdb(input logic [2:0] t, input logic [31:0] v, input logic [31:0] a);
    cdb_valid = 1'b1; cdb_tag = t; cdb_value = v; cdb_addr = a;
    cycle();
    cdb_valid = 1'b0;
  endtask

  task automatic bra(input logic [2:0] t, input logic taken);
    bra_valid = 1'b1; bra_tag = t; bra_taken = taken;
    cycle();
    bra_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; disp_valid = 1'b0; disp_op = 2'd0; disp_reg = '0; disp_pred = 1'b0;
    disp_alt_pc = '0; disp_baddr = '0; chk1_tag = '0; chk2_tag = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0; cdb_addr = '0;
    bra_valid = 1'b0; bra_tag = '0; bra_taken = 1'b0; mem_ack = 1'b0;
    cycle(); cycle();
    rst = 1'b1;

    check("rst_count", count, 0);
    check("rst_reg_we", reg_we, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_disp_ready", disp_ready, 1);
    check("rst_disp_tag", disp_tag, 0);

    // Fill to 8, complete in reverse, expect in-order commit.
    for (int i = 0; i < 8; i++) begin
      check("fill_tag", disp_tag, 64'(i));
      dispatch(2'd3, 5'(i + 1), 1'b0, 32'h0, 8'h0);
    end
    check("full_count", count, 8);
    check("full_ready", disp_ready, 0);
    dispatch(2'd3, 5'd31, 1'b0, 32'h0, 8'h0);
    check("full_drop_count", count, 8);
    for (int t = 7; t >= 0; t--) cdb(3'(t), 32'h100 + 32'(t), 32'h0);
    check("no_early_commit", reg_we, 0);
    for (int k = 0; k < 8; k++) begin
      cycle();
      check("drain_we", reg_we, 1);
      check("drain_tag", reg_tag, 64'(k));
      check("drain_name", reg_name, 64'(k + 1));
      check("drain_data", reg_data, 64'(32'h100 + 32'(k)));
    end
    check("drain_count", count, 0);
    cycle();
    check("drain_pulse_end", reg_we, 0);

    // Forwarding: tags 0..3 pending.
    for (int i = 0; i < 4; i++) dispatch(2'd3, 5'(10 + i), 1'b0, 32'h0, 8'h0);
    chk1_tag = 3'd3; chk2_tag = 3'd2;
    cdb_valid = 1'b1; cdb_tag = 3'd3; cdb_value = 32'hDEAD; cdb_addr = 32'h0;
    #1;
    check("fwd_ready", chk1_ready, 1);
    check("fwd_value", chk1_value, 32'hDEAD);
    check("pend_ready", chk2_ready, 0);
    check("pend_value", chk2_value, 0);
    cycle();
    cdb_valid = 1'b0;
    #1;
    check("entry_ready", chk1_ready, 1);
    check("entry_value", chk1_value, 32'hDEAD);
    cdb(3'd3, 32'hBEEF, 32'h0);
    check("done_wb_ignored", chk1_value, 32'hDEAD);
    cdb(3'd0, 32'h10, 32'h0);
    cdb(3'd1, 32'h11, 32'h0);
    cdb(3'd2, 32'h12, 32'h0);
    cycle(); cycle();
    check("fwd_commit_tag", reg_tag, 3);
    check("fwd_commit_data", reg_data, 32'hDEAD);
    check("fwd_count", count, 0);

    // Store backpressure: store tag 4, normal tag 5.
    dispatch(2'd2, 5'd0, 1'b0, 32'h0, 8'h0);
    dispatch(2'd3, 5'd7, 1'b0, 32'h0, 8'h0);
    cdb(3'd4, 32'h55, 32'h100);
    cdb(3'd5, 32'h77, 32'h0);
    check("st_we", mem_we, 1);
    check("st_addr", mem_addr, 32'h100);
    check("st_data", mem_data, 32'h55);
    for (int j = 0; j < 3; j++) begin
      cycle();
      check("st_hold_we", mem_we, 1);
      check("st_hold_addr", mem_addr, 32'h100);
    end
    mem_ack = 1'b1;
    cycle();
    mem_ack = 1'b0;
    check("st_release", mem_we, 0);
    check("st_no_reg_yet", reg_we, 0);
    check("st_count", count, 1);
    cycle();
    check("st_next_we", reg_we, 1);
    check("st_next_tag", reg_tag, 5);
    check("st_next_data", reg_data, 32'h77);

    // Mispredict: branch tag 6 + three younger ops.
    dispatch(2'd1, 5'd0, 1'b1, 32'h40, 8'h12);
    for (int i = 0; i < 3; i++) dispatch(2'd3, 5'd1, 1'b0, 32'h0, 8'h0);
    bra(3'd6, 1'b0);
    disp_valid = 1'b1; disp_op = 2'd3;
    cycle();
    check("mp_pc_modify", pc_modify, 1);
    check("mp_npc", npc, 32'h40);
    check("mp_brp_update", brp_update, 1);
    check("mp_brp_addr", brp_addr, 8'h12);
    check("mp_brp_taken", brp_taken, 0);
    check("mp_pattern", brp_pattern, 0);
    check("mp_count", count, 0);
    check("mp_disp_tag", disp_tag, 7);
    check("mp_blocked", disp_ready, 0);
    cycle();
    disp_valid = 1'b0;
    chk1_tag = 3'd7;
    #1;
    check("mp_pulse_end", pc_modify, 0);
    check("mp_count_after", count, 0);
    check("mp_ready_after", disp_ready, 1);
    check("mp_tag_after", disp_tag, 7);
    check("mp_flushed_entry", chk1_ready, 0);

    // History: correctly predicted taken, then not-taken.
    dispatch(2'd1, 5'd0, 1'b1, 32'h80, 8'h21);
    bra(3'd7, 1'b1);
    cycle();
    check("br1_update", brp_update, 1);
    check("br1_pattern", brp_pattern, 2'b00);
    check("br1_taken", brp_taken, 1);
    check("br1_no_redirect", pc_modify, 0);
    dispatch(2'd1, 5'd0, 1'b0, 32'h90, 8'h22);
    bra(3'd0, 1'b0);
    cycle();
    check("br2_pattern", brp_pattern, 2'b01);
    check("br2_addr", brp_addr, 8'h22);
    check("br2_no_redirect", pc_modify, 0);

    // Wrap: 20 dispatch/commit pairs starting at tag 1.
    for (int i = 0; i < 20; i++) begin
      check("wrap_disp_tag", disp_tag, 64'((1 + i) % 8));
      dispatch(2'd3, 5'(i), 1'b0, 32'h0, 8'h0);
      cdb(3'((1 + i) % 8), 32'h1000 + 32'(i), 32'h0);
      cycle();
      check("wrap_reg_tag", reg_tag, 64'((1 + i) % 8));
      check("wrap_reg_data", reg_data, 64'(32'h1000 + 32'(i)));
    end
    check("wrap_count", count, 0);

    // Reset mid-operation: store tag 5 stalled, four more pending.
    dispatch(2'd2, 5'd0, 1'b0, 32'h0, 8'h0);
    for (int i = 0; i < 4; i++) dispatch(2'd3, 5'd2, 1'b0, 32'h0, 8'h0);
    cdb(3'd5, 32'h99, 32'h200);
    cycle();
    check("rm_store_we", mem_we, 1);
    check("rm_count", count, 5);
    cycle();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    check("rm_mem_we", mem_we, 0);
    check("rm_mem_addr", mem_addr, 0);
    check("rm_count0", count, 0);
    check("rm_reg_data", reg_data, 0);
    check("rm_npc", npc, 0);
    check("rm_disp_tag", disp_tag, 0);
    dispatch(2'd3, 5'd3, 1'b0, 32'h0, 8'h0);
    cdb(3'd0, 32'hABC, 32'h0);
    cycle();
    check("rm_commit_we", reg_we, 1);
    check("rm_commit_tag", reg_tag, 0);
    check("rm_commit_name", reg_name, 3);
    check("rm_commit_data", reg_data, 32'hABC);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rob_param.md
# rob_param

Parametrised reorder buffer for the out-of-order core, the successor to the fixed 8-entry ROB. It sits between the decoder (dispatch, operand check), the CDB and branch ALU (writeback), and the register file, data memory, PC and branch predictor (in-order commit). New behaviour over the previous generation:
- configurable depth and widths;
- true full/empty occupancy;
- store commit to memory with an ack handshake;
- CDB forwarding on the check ports;
- a single, registered mispredict flush.

## Interface
- DEPTH, 8, entry count; power of 2, ≥2
- ENTRY_W, 3, log2(DEPTH); tag width
- DATA_W, 32, result/store data width
- ADDR_W, 32, store address width
- REG_W, 5, architectural register index width
- PC_W, 32, instruction address width
- BADDR_W, 8, predictor index width
- HIST_W, 2, global branch history width

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-low reset
- disp_valid  in  1  dispatch request
- disp_ready  out  1  = (count != DEPTH) && !flush_q
- disp_tag  out  ENTRY_W  tail pointer; tag given to the dispatched op
- disp_op  in  2  0 nop, 1 branch, 2 store, 3 normal
- disp_reg  in  REG_W  destination register
- disp_pred  in  1  predicted taken
- disp_alt_pc  in  PC_W  redirect target if mispredicted
- disp_baddr  in  BADDR_W  predictor index
- chk1_tag / chk2_tag  in  ENTRY_W  operand lookup tags
- chk1_value / chk2_value  out  DATA_W  combinational lookup result
- chk1_ready / chk2_ready  out  1  combinational lookup valid
- cdb_valid  in  1  CDB writeback strobe
- cdb_tag  in  ENTRY_W  CDB destination tag
- cdb_value  in  DATA_W  CDB result
- cdb_addr  in  ADDR_W  CDB store address
- bra_valid  in  1  branch resolve strobe
- bra_tag  in  ENTRY_W  resolved branch tag
- bra_taken  in  1  actual branch outcome
- reg_we  out  1  register write pulse
- reg_name  out  REG_W  register index
- reg_data  out  DATA_W  register data
- reg_tag  out  ENTRY_W  committing entry's tag
- mem_we  out  1  store request
- mem_addr  out  ADDR_W  store address
- mem_data  out  DATA_W  store data
- mem_ack  in  1  store accepted
- pc_modify  out  1  PC redirect pulse
- npc  out  PC_W  redirect target
- brp_update  out  1  predictor update pulse
- brp_addr  out  BADDR_W  predictor index
- brp_taken  out  1  actual outcome
- brp_pattern  out  HIST_W  history before this branch
- count  out  ENTRY_W+1  current occupancy

## Operation
**Entry fields:** valid, done, op, reg, pred, taken, alt_pc, baddr, value, addr.

**Dispatch:** when disp_valid && disp_ready, write the entry at the tail, set done=0, tail+1.

**Writeback:**
- When cdb_valid and entry[cdb_tag] is valid and not done: set done=1 and capture value/addr.
- When bra_valid: same rule, set done=1 and capture taken.
- Both strobes may hit different tags in the same cycle; both are applied.
- Writebacks to invalid or done entries are ignored.

**Check ports:** for each port, the first matching rule wins:
1. entry valid && done → ready=1, value=entry.value.
2. cdb_valid && cdb_tag==chk_tag && entry valid → ready=1, value=cdb_value (forward).
3. Otherwise ready=0, value=0.

**Commit:** at most one head entry per cycle, and only when count≠0 && head.done.
- nop: retire with no outputs.
- normal: reg_we=1 with reg/value/tag.
- store: drive mem_we=1 and mem_addr/mem_data, held stable until a cycle where mem_ack=1. The entry retires in that cycle. No later entry may retire first.
- branch: brp_update=1 with baddr, taken, and the pre-update history; history ← {history[HIST_W-2:0], taken}.
- Mispredict (taken ≠ pred): pc_modify=1, npc=alt_pc; set flush_q.

**Flush:**
- The flush is applied at the same edge the branch retires.
- All valid bits clear, head=tail=old_head+1, count=0.
- A dispatch presented in that cycle is discarded.
- flush_q blocks dispatch for exactly one following cycle.

**Counters:**
- count is ENTRY_W+1 bits: +1 on dispatch, −1 on retire, unchanged when both happen.
- Pointers wrap modulo DEPTH.
- Dispatch while full: dropped (disp_ready=0).

## Timing
- Reset (rst=0 at an edge) forces: all outputs 0, pointers 0, count 0, history 0, all valid/done bits 0. This applies mid-store as well: mem_we drops the next cycle.
- Commit outputs are registered; every pulse (reg_we, brp_update, pc_modify) lasts one cycle.
- Minimum latency:
  - dispatch at edge t;
  - writeback accepted at edge t+1 at the earliest;
  - the commit pulse is visible after edge t+2.
- A writeback to the head in the same cycle as a commit evaluation does not commit that cycle. It commits the next cycle.
- A store with mem_ack tied high commits in 1 cycle. mem_ack is ignored while mem_we=0.
- Simultaneous dispatch and retire at full (count=DEPTH): the retire frees a slot only in the next cycle, so disp_ready stays 0 in the current cycle.

## Test plan
- **Fill/drain:** DEPTH=8, dispatch 8 normal ops → count=8, disp_ready=0. CDB-complete tags 7..0 in reverse → reg_we pulses in order of tags 0..7, one per cycle; count returns to 0.
- **Forwarding:** chk1_tag=3 (pending) in the same cycle as cdb_valid, tag 3, value 0xDEAD → chk1_ready=1, chk1_value=0xDEAD. In the next cycle it is served from the entry.
- **Store backpressure:** head store addr 0x100, data 0x55, mem_ack low for 3 cycles → mem_we held 4 cycles; the following normal op commits the cycle after the ack.
- **Mispredict:** branch with pred=1 resolves taken=0, alt_pc 0x40, 3 younger ops pending → pc_modify=1, npc=0x40; count=0; a dispatch in the flush cycle is dropped; disp_tag equals branch tag+1.
- **Wrap:** 20 dispatch/commit pairs at DEPTH=8 → tags wrap 7→0; count never exceeds 8; no lost commits.
- **Reset mid-operation:** rst low with 5 entries pending and a store stalled → all outputs 0 the next cycle; count=0; a subsequent dispatch receives tag 0.
